// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared FSM encoding, FFT RAM geometry defaults and peak record for the magnitude RAM writer/reader
package spectrum_pkg;
  localparam int ADDR_W_D = 8;
  localparam int DATA_W_D = 16;
  localparam int NUM_BINS_D = 128;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
  typedef struct packed {
    logic [ADDR_W_D-1:0] idx;
    logic [DATA_W_D-1:0] mag;
  } peak_t;
endpackage

// File: rtl/spectrum_peak_reader_peak_top2.sv
// peak_top2: keeps the two largest candidates of a scan; candidates arrive in ascending index so strict compares keep the earlier bin on ties
module peak_top2
  import spectrum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_mag,
  output logic [ADDR_W-1:0] o_p1_idx,
  output logic [DATA_W-1:0] o_p1_mag,
  output logic [ADDR_W-1:0] o_p2_idx,
  output logic [DATA_W-1:0] o_p2_mag,
  output logic [1:0]        o_cnt
);
  logic [ADDR_W-1:0] r_p1_idx, r_p2_idx;
  logic [DATA_W-1:0] r_p1_mag, r_p2_mag;
  logic [1:0]        r_cnt;
  // Insert a candidate into the sorted top-2 and count it, saturating at two
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_p1_idx <= '0;
      r_p1_mag <= '0;
      r_p2_idx <= '0;
      r_p2_mag <= '0;
      r_cnt    <= '0;
    end else if (i_vld) begin
      if (i_mag > r_p1_mag) begin
        r_p2_idx <= r_p1_idx;
        r_p2_mag <= r_p1_mag;
        r_p1_idx <= i_idx;
        r_p1_mag <= i_mag;
      end else if (i_mag > r_p2_mag) begin
        r_p2_idx <= i_idx;
        r_p2_mag <= i_mag;
      end
      r_cnt <= (r_cnt == 2'd2) ? 2'd2 : r_cnt + 2'd1;
    end
  end
  assign o_p1_idx = r_p1_idx;
  assign o_p1_mag = r_p1_mag;
  assign o_p2_idx = r_p2_idx;
  assign o_p2_mag = r_p2_mag;
  assign o_cnt    = r_cnt;
endmodule

// File: rtl/spectrum_peak_reader.sv
// spectrum_peak_reader: reads the FFT magnitude RAM after wr_done and reports the two largest local maxima; define PEAK_THRESH_EN for a minimum-magnitude filter
module spectrum_peak_reader
  import spectrum_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int NUM_BINS  = NUM_BINS_D,
  parameter int SKIP_BINS = 2,
  parameter int RD_LAT    = 1
`ifdef PEAK_THRESH_EN
  ,
  parameter logic [DATA_W-1:0] THRESH = DATA_W'(64)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak1_idx,
  output logic [DATA_W-1:0] peak1_mag,
  output logic [ADDR_W-1:0] peak2_idx,
  output logic [DATA_W-1:0] peak2_mag,
  output logic [1:0]        peak_cnt
);
  localparam int DW = $clog2(RD_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BINS - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(RD_LAT + 1);
  state_t            r_state, w_next;
  logic              r_start_q, w_start_acc, w_flush, w_dv, w_cand, w_thr_ok;
  logic [ADDR_W-1:0] r_cnt, r_rd_addr, r_k1;
  logic [DW-1:0]     r_dcnt;
  logic              r_rd_en, r_have;
  logic [RD_LAT-1:0] r_vld;
  logic [ADDR_W-1:0] r_tag [RD_LAT];
  logic [DATA_W-1:0] r_m1, r_m2, w_next_mag;
  assign w_start_acc = start && !r_start_q && (r_state == IDLE || r_state == DONE);
  assign w_flush     = (r_state == DRAIN) && (r_dcnt == DRAIN_END);
  assign w_dv        = r_vld[RD_LAT-1];
  assign w_next_mag  = w_dv ? rd_data : '0;
`ifdef PEAK_THRESH_EN
  assign w_thr_ok = r_m1 >= THRESH;
`else
  assign w_thr_ok = 1'b1;
`endif
  // Bin r_k1 is a peak when it rises above its left neighbour and is not exceeded by the right one (0 past the last bin)
  assign w_cand = ((w_dv && r_have) || w_flush) && (r_m1 > r_m2) && (r_m1 >= w_next_mag)
                  && (r_k1 >= ADDR_W'(SKIP_BINS)) && w_thr_ok;
  // Start edge detector; clear keeps sampling start so a level still held high cannot retrigger
  always_ff @(posedge clk) r_start_q <= rst ? 1'b0 : start;
  // FSM state register
  always_ff @(posedge clk) r_state <= (rst || clear) ? IDLE : w_next;
  // FSM next state
  always_comb begin
    w_next = r_state;
    if (w_start_acc) w_next = READ;
    else if (r_state == READ && r_cnt == LAST) w_next = DRAIN;
    else if (w_flush) w_next = DONE;
  end
  // Sequential read address generator and drain timer
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_dcnt    <= '0;
    end else begin
      r_rd_en   <= r_state == READ;
      r_rd_addr <= (r_state == READ) ? r_cnt : r_rd_addr;
      r_cnt     <= (r_state == READ) ? r_cnt + ADDR_W'(1) : '0;
      r_dcnt    <= (r_state == DRAIN) ? r_dcnt + DW'(1) : '0;
    end
  end
  // Valid/address tags travel alongside the RAM latency so each returning word knows its bin
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= r_rd_en;
      r_tag[0] <= r_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end
  // Two-sample history window; m[-1] is the zero left in r_m2 at scan start
  always_ff @(posedge clk) begin
    if (rst || clear || w_start_acc) begin
      r_m1   <= '0;
      r_m2   <= '0;
      r_k1   <= '0;
      r_have <= 1'b0;
    end else if (w_dv) begin
      r_m2   <= r_m1;
      r_m1   <= rd_data;
      r_k1   <= r_tag[RD_LAT-1];
      r_have <= 1'b1;
    end
  end
  peak_top2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_top2 (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (clear || w_start_acc),
    .i_vld    (w_cand),
    .i_idx    (r_k1),
    .i_mag    (r_m1),
    .o_p1_idx (peak1_idx),
    .o_p1_mag (peak1_mag),
    .o_p2_idx (peak2_idx),
    .o_p2_mag (peak2_mag),
    .o_cnt    (peak_cnt)
  );
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign busy    = (r_state == READ) || (r_state == DRAIN);
  assign done    = r_state == DONE;
endmodule

// File: tb/tb_spectrum_peak_reader.sv
// tb_spectrum_peak_reader: table vectors, clear/reset sequences and random RAM contents against a whole-array peak model
module tb_spectrum_peak_reader;
  import spectrum_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
  logic        rd_en, busy, done;
  logic [7:0]  rd_addr, peak1_idx, peak2_idx;
  logic [15:0] rd_data = '0, peak1_mag, peak2_mag;
  logic [1:0]  peak_cnt;
  logic [15:0] mem [256];
  int          n_chk = 0, n_fail = 0, rd_cnt = 0, addr_err = 0;
  typedef struct {
    logic [15:0] bg;
    int          i0; logic [15:0] m0;
    int          i1; logic [15:0] m1;
    int          i2; logic [15:0] m2;
    logic [7:0]  e1i; logic [15:0] e1m;
    logic [7:0]  e2i; logic [15:0] e2m;
    logic [1:0]  ec;
  } vec_t;
  vec_t tv [8];
  spectrum_peak_reader dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done),
    .peak1_idx(peak1_idx), .peak1_mag(peak1_mag),
    .peak2_idx(peak2_idx), .peak2_mag(peak2_mag),
    .peak_cnt(peak_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(negedge clk) if (rd_en) begin
    if (rd_addr != rd_cnt[7:0]) addr_err++;
    rd_cnt++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic void model(output peak_t p1, output peak_t p2, output logic [1:0] cnt);
    int q[$];
    logic ok;
    for (int b = 2; b < 128; b++) begin
      ok = mem[b] > mem[b-1] && mem[b] >= ((b == 127) ? 16'd0 : mem[b+1]);
`ifdef PEAK_THRESH_EN
      ok = ok && mem[b] >= 16'd64;
`endif
      if (ok) q.push_back(b);
    end
    cnt = 2'((q.size() > 2) ? 2 : q.size());
    p1 = '0;
    p2 = '0;
    foreach (q[i]) if (mem[q[i]] > p1.mag) begin p1.idx = 8'(q[i]); p1.mag = mem[q[i]]; end
    foreach (q[i]) if (8'(q[i]) != p1.idx && mem[q[i]] > p2.mag) begin p2.idx = 8'(q[i]); p2.mag = mem[q[i]]; end
  endfunction
  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = (i < 128) ? v.bg : 16'd0;
    if (v.i0 >= 0) mem[v.i0] = v.m0;
    if (v.i1 >= 0) mem[v.i1] = v.m1;
    if (v.i2 >= 0) mem[v.i2] = v.m2;
  endtask
  task automatic scan(input string nm, input logic [7:0] e1i, input logic [15:0] e1m,
                      input logic [7:0] e2i, input logic [15:0] e2m, input logic [1:0] ec);
    int n;
    @(negedge clk);
    rd_cnt = 0;
    addr_err = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("%s.busy_start", nm), busy, 1);
    chk($sformatf("%s.done_start", nm), done, 0);
    chk($sformatf("%s.p1_cleared", nm), peak1_mag, 0);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk($sformatf("%s.done_edge", nm), n, 131);
    chk($sformatf("%s.reads", nm), rd_cnt, 128);
    chk($sformatf("%s.addr_errs", nm), addr_err, 0);
    chk($sformatf("%s.busy_end", nm), busy, 0);
    chk($sformatf("%s.p1_idx", nm), peak1_idx, e1i);
    chk($sformatf("%s.p1_mag", nm), peak1_mag, e1m);
    chk($sformatf("%s.p2_idx", nm), peak2_idx, e2i);
    chk($sformatf("%s.p2_mag", nm), peak2_mag, e2m);
    chk($sformatf("%s.cnt", nm), peak_cnt, ec);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("%s.hold_p1", nm), peak1_mag, e1m);
    chk($sformatf("%s.hold_done", nm), done, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int n, bz;
    peak_t p1, p2;
    logic [1:0] c;
    tv[0] = '{0, -1, 0, -1, 0, -1, 0, 0, 0, 0, 0, 0};
    tv[1] = '{5, 10, 1000, 40, 3000, -1, 0, 40, 3000, 10, 1000, 2};
    tv[2] = '{0, 1, 9000, 50, 200, -1, 0, 50, 200, 0, 0, 1};
    tv[3] = '{0, 20, 500, 90, 500, -1, 0, 20, 500, 90, 500, 2};
    tv[4] = '{0, 20, 500, 90, 500, 127, 700, 127, 700, 20, 500, 2};
`ifdef PEAK_THRESH_EN
    tv[5] = '{0, 30, 63, 70, 64, -1, 0, 70, 64, 0, 0, 1};
`else
    tv[5] = '{0, 30, 63, 70, 64, -1, 0, 70, 64, 30, 63, 2};
`endif
    tv[6] = '{0, 60, 300, 61, 300, -1, 0, 60, 300, 0, 0, 1};
    tv[7] = '{0, 0, 50, 2, 100, -1, 0, 2, 100, 0, 0, 1};
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.rd_en", rd_en, 0);
    chk("rst.rd_addr", rd_addr, 0);
    chk("rst.p1", {peak1_idx, peak1_mag}, 0);
    chk("rst.p2", {peak2_idx, peak2_mag}, 0);
    chk("rst.cnt", peak_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load(tv[i]);
      scan($sformatf("vec%0d", i), tv[i].e1i, tv[i].e1m, tv[i].e2i, tv[i].e2m, tv[i].ec);
    end
    load(tv[1]);
    @(negedge clk);
    rd_cnt = 0;
    start = 1'b1;
    n = 0;
    while (rd_cnt < 60 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("clr.pre_p1", peak1_mag, 3000);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clr.busy", busy, 0);
    chk("clr.rd_en", rd_en, 0);
    chk("clr.rd_addr", rd_addr, 0);
    chk("clr.p1", {peak1_idx, peak1_mag}, 0);
    chk("clr.cnt", peak_cnt, 0);
    @(negedge clk);
    clear = 1'b0;
    bz = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy || rd_en) bz++;
    end
    chk("clr.no_retrigger", bz, 0);
    @(negedge clk);
    start = 1'b0;
    scan("clr.rescan", 40, 3000, 10, 1000, 2);
    load(tv[3]);
    @(negedge clk);
    start = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.rd_en", rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    scan("rstmid.rescan", 20, 500, 90, 500, 2);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom_range(0, (r % 2 == 1) ? 4000 : 6));
      model(p1, p2, c);
      scan($sformatf("rnd%0d", r), p1.idx, p1.mag, p2.idx, p2.mag, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
